// File: rtl/prco_mem_arb_if.sv
// Requester, memory and status signals of the local-memory arbiter.
// The master modport is the arbiter; the slave modport is its environment
// (the three requesters plus the memory macro).
interface prco_mem_arb_if #(
    parameter int P_ADDR_W = 16,
    parameter int P_DATA_W = 16
);
    logic                i_f_req;
    logic [P_ADDR_W-1:0] i_f_addr;
    logic                q_f_ack;
    logic [P_DATA_W-1:0] q_f_data;

    logic                i_d_req;
    logic                i_d_we;
    logic [P_ADDR_W-1:0] i_d_addr;
    logic [P_DATA_W-1:0] i_d_dina;
    logic                q_d_ack;
    logic [P_DATA_W-1:0] q_d_data;

    logic                i_x_req;
    logic                i_x_we;
    logic [P_ADDR_W-1:0] i_x_addr;
    logic [P_DATA_W-1:0] i_x_dina;
    logic                q_x_ack;
    logic [P_DATA_W-1:0] q_x_data;

    logic                q_mem_ce;
    logic                q_mem_we;
    logic [P_ADDR_W-1:0] q_mem_addr;
    logic [P_DATA_W-1:0] q_mem_dina;
    logic [P_DATA_W-1:0] i_mem_douta;

    logic                q_busy;
    logic [1:0]          q_grant;
    logic                q_err;

    modport master (
        input  i_f_req, i_f_addr,
        output q_f_ack, q_f_data,
        input  i_d_req, i_d_we, i_d_addr, i_d_dina,
        output q_d_ack, q_d_data,
        input  i_x_req, i_x_we, i_x_addr, i_x_dina,
        output q_x_ack, q_x_data,
        output q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
        input  i_mem_douta,
        output q_busy, q_grant, q_err
    );

    modport slave (
        output i_f_req, i_f_addr,
        input  q_f_ack, q_f_data,
        output i_d_req, i_d_we, i_d_addr, i_d_dina,
        input  q_d_ack, q_d_data,
        output i_x_req, i_x_we, i_x_addr, i_x_dina,
        input  q_x_ack, q_x_data,
        input  q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
        output i_mem_douta,
        input  q_busy, q_grant, q_err
    );
endinterface

// File: rtl/prco_mem_arb.sv
// Single-port local-memory arbiter: serialises fetch (F), load/store (D)
// and debug loader (X) accesses, waits the memory read latency and returns
// data with a one-cycle ack. X is promoted to top priority after losing
// P_STARVE_LIMIT arbitrations.
module prco_mem_arb #(
    parameter int P_ADDR_W       = 16,
    parameter int P_DATA_W       = 16,
    parameter int P_LMEM_DEPTH   = 255,
    parameter int P_MEM_LAT      = 1,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    prco_mem_arb_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_F    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;
    localparam logic [1:0] G_X    = 2'd3;

    localparam int SW = (P_STARVE_LIMIT < 1) ? 1 : $clog2(P_STARVE_LIMIT + 1);
    localparam logic [SW-1:0]       STARVE_MAX = SW'(P_STARVE_LIMIT);
    localparam logic [2:0]          LAT_INIT   = 3'(P_MEM_LAT - 1);
    localparam logic [P_ADDR_W-1:0] LMEM_MAX   = P_ADDR_W'(P_LMEM_DEPTH);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          mask_q, mask_d;
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic [P_ADDR_W-1:0] addr_q, addr_d;
    logic [P_DATA_W-1:0] dina_q, dina_d;
    logic [2:0]          lat_q, lat_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [P_DATA_W-1:0] f_data_q, f_data_d;
    logic [P_DATA_W-1:0] d_data_q, d_data_d;
    logic [P_DATA_W-1:0] x_data_q, x_data_d;

    logic                f_req, d_req, x_req;
    logic [1:0]          winner;
    logic [P_DATA_W-1:0] rd_value;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            grant_q  <= G_NONE;
            mask_q   <= G_NONE;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= '0;
            dina_q   <= '0;
            lat_q    <= '0;
            starve_q <= '0;
            f_data_q <= '0;
            d_data_q <= '0;
            x_data_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            we_q     <= we_d;
            oor_q    <= oor_d;
            addr_q   <= addr_d;
            dina_q   <= dina_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            f_data_q <= f_data_d;
            d_data_q <= d_data_d;
            x_data_q <= x_data_d;
        end
    end

    // Next-state: arbitration and latching in IDLE, latency count in WAIT.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        we_d     = we_q;
        oor_d    = oor_q;
        addr_d   = addr_q;
        dina_d   = dina_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        f_data_d = f_data_q;
        d_data_d = d_data_q;
        x_data_d = x_data_q;
        rd_value = '0;
        winner   = G_NONE;

        // The requester acked last is ignored for one IDLE cycle so a late
        // req drop does not start a duplicate access.
        f_req = bus.i_f_req && (mask_q != G_F);
        d_req = bus.i_d_req && (mask_q != G_D);
        x_req = bus.i_x_req && (mask_q != G_X);

        case (state_q)
            S_IDLE: begin
                mask_d = G_NONE;
                if (x_req && (starve_q == STARVE_MAX)) winner = G_X;
                else if (d_req)                        winner = G_D;
                else if (f_req)                        winner = G_F;
                else if (x_req)                        winner = G_X;

                if (winner != G_NONE) begin
                    state_d = S_ISSUE;
                    grant_d = winner;
                    case (winner)
                        G_F: begin
                            addr_d = bus.i_f_addr;
                            we_d   = 1'b0;
                            dina_d = '0;
                        end
                        G_D: begin
                            addr_d = bus.i_d_addr;
                            we_d   = bus.i_d_we;
                            dina_d = bus.i_d_dina;
                        end
                        default: begin
                            addr_d = bus.i_x_addr;
                            we_d   = bus.i_x_we;
                            dina_d = bus.i_x_dina;
                        end
                    endcase
                    oor_d = (addr_d > LMEM_MAX);
                    if (winner == G_X) begin
                        starve_d = '0;
                    end else if (x_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
            end
            S_WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d  = S_RESP;
                    rd_value = oor_q ? '0 : bus.i_mem_douta;
                    if (!we_q) begin
                        case (grant_q)
                            G_F:     f_data_d = rd_value;
                            G_D:     d_data_d = rd_value;
                            G_X:     x_data_d = rd_value;
                            default: ;
                        endcase
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
                mask_d  = grant_q;
            end
        endcase
    end

    // Outputs: memory strobe in ISSUE (suppressed out of range), ack in RESP.
    always_comb begin
        bus.q_mem_ce   = (state_q == S_ISSUE) && !oor_q;
        bus.q_mem_we   = bus.q_mem_ce && we_q;
        bus.q_mem_addr = bus.q_mem_ce ? addr_q : '0;
        bus.q_mem_dina = bus.q_mem_ce ? dina_q : '0;
        bus.q_busy     = (state_q != S_IDLE);
        bus.q_grant    = grant_q;
        bus.q_f_ack    = (state_q == S_RESP) && (grant_q == G_F);
        bus.q_d_ack    = (state_q == S_RESP) && (grant_q == G_D);
        bus.q_x_ack    = (state_q == S_RESP) && (grant_q == G_X);
        bus.q_err      = (state_q == S_RESP) && oor_q;
        bus.q_f_data   = f_data_q;
        bus.q_d_data   = d_data_q;
        bus.q_x_data   = x_data_q;
    end
endmodule

// File: tb/tb_prco_mem_arb.sv
// Bench for prco_mem_arb: expected acks and memory strobes are queued as
// stimulus is issued, and a negedge monitor pops and compares them.
module tb_prco_mem_arb;
    localparam logic [1:0] PF = 2'd1;
    localparam logic [1:0] PD = 2'd2;
    localparam logic [1:0] PX = 2'd3;

    typedef struct {
        logic [1:0]  port;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] dina;
        int          cyc;
    } mem_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ack_t expAck[$];
    mem_t expMem[$];

    logic [15:0] mem [256];
    logic        memLoaded = 1'b0;
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    int   monCount;
    logic [1:0]  monPort;
    logic [15:0] monData;
    ack_t monAck;
    mem_t monMem;

    logic [1:0] starveOrder [11];

    prco_mem_arb_if #(.P_ADDR_W(16), .P_DATA_W(16)) bus ();
    prco_mem_arb_if #(.P_ADDR_W(16), .P_DATA_W(16)) bus3 ();

    prco_mem_arb #(.P_MEM_LAT(1)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    prco_mem_arb #(.P_MEM_LAT(3)) dut3 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory stub: read data is valid only in the cycle P_MEM_LAT after the
    // strobe and 0xDEAD otherwise, so a mistimed sample is visible.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            mem[5]    <= 16'h2002;
            memLoaded <= 1'b1;
            pipe1     <= 16'hDEAD;
            pipe3[0]  <= 16'hDEAD;
            pipe3[1]  <= 16'hDEAD;
            pipe3[2]  <= 16'hDEAD;
        end else begin
            pipe1 <= 16'hDEAD;
            if (bus.q_mem_ce) begin
                pipe1 <= mem[bus.q_mem_addr[7:0]];
                if (bus.q_mem_we) mem[bus.q_mem_addr[7:0]] <= bus.q_mem_dina;
            end
            pipe3[0] <= bus3.q_mem_ce ? mem[bus3.q_mem_addr[7:0]] : 16'hDEAD;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end

    assign bus.i_mem_douta  = pipe1;
    assign bus3.i_mem_douta = pipe3[2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushAck(input logic [1:0] p, input logic [15:0] d, input logic e, input int c);
        ack_t a;
        a.port = p; a.data = d; a.err = e; a.cyc = c;
        expAck.push_back(a);
    endtask

    task automatic pushMem(input logic [15:0] a, input logic w, input logic [15:0] d, input int c);
        mem_t m;
        m.addr = a; m.we = w; m.dina = d; m.cyc = c;
        expMem.push_back(m);
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic we, input logic [15:0] addr, input logic [15:0] dina);
        case (p)
            PF: begin bus.i_f_addr = addr; bus.i_f_req = 1'b1; end
            PD: begin bus.i_d_we = we; bus.i_d_addr = addr; bus.i_d_dina = dina; bus.i_d_req = 1'b1; end
            default: begin bus.i_x_we = we; bus.i_x_addr = addr; bus.i_x_dina = dina; bus.i_x_req = 1'b1; end
        endcase
    endtask

    // Requesters drop req in their ack cycle; returns once everything is idle.
    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.q_f_ack) bus.i_f_req = 1'b0;
            if (bus.q_d_ack) bus.i_d_req = 1'b0;
            if (bus.q_x_ack) bus.i_x_req = 1'b0;
            if (!bus.i_f_req && !bus.i_d_req && !bus.i_x_req && !bus.q_busy) break;
            n++;
            if (n >= budget) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout: still busy=%0b after %0d cycles, required idle", bus.q_busy, budget);
                bus.i_f_req = 1'b0; bus.i_d_req = 1'b0; bus.i_x_req = 1'b0;
                break;
            end
        end
    endtask

    // Monitor: compares every ack and every memory strobe against the queues.
    always @(negedge clk) begin
        monCount = int'(bus.q_f_ack) + int'(bus.q_d_ack) + int'(bus.q_x_ack);
        if (monCount != 0) begin
            checkOutput("ackOneHot", monCount, 1);
            if (bus.q_f_ack) begin
                monPort = PF; monData = bus.q_f_data;
            end else if (bus.q_d_ack) begin
                monPort = PD; monData = bus.q_d_data;
            end else begin
                monPort = PX; monData = bus.q_x_data;
            end
            if (expAck.size() == 0) begin
                checkOutput("ackUnexpected", monCount, 0);
            end else begin
                monAck = expAck.pop_front();
                checkOutput("ackPort", monPort, monAck.port);
                checkOutput("ackGrant", bus.q_grant, monAck.port);
                checkOutput("ackData", monData, monAck.data);
                checkOutput("ackErr", bus.q_err, monAck.err);
                if (monAck.cyc >= 0) checkOutput("ackCycle", cyc, monAck.cyc);
            end
        end else if (bus.q_err) begin
            checkOutput("errWithoutAck", bus.q_err, 0);
        end
        if (bus.q_mem_ce) begin
            if (expMem.size() == 0) begin
                checkOutput("memCeUnexpected", bus.q_mem_ce, 0);
            end else begin
                monMem = expMem.pop_front();
                checkOutput("memAddr", bus.q_mem_addr, monMem.addr);
                checkOutput("memWe", bus.q_mem_we, monMem.we);
                if (monMem.we) checkOutput("memDina", bus.q_mem_dina, monMem.dina);
                if (monMem.cyc >= 0) checkOutput("memCycle", cyc, monMem.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int xAcks;
        int xRaiseAt;
        bit got3;

        bus.i_f_req = 0; bus.i_f_addr = 0;
        bus.i_d_req = 0; bus.i_d_we = 0; bus.i_d_addr = 0; bus.i_d_dina = 0;
        bus.i_x_req = 0; bus.i_x_we = 0; bus.i_x_addr = 0; bus.i_x_dina = 0;
        bus3.i_f_req = 0; bus3.i_f_addr = 0;
        bus3.i_d_req = 0; bus3.i_d_we = 0; bus3.i_d_addr = 0; bus3.i_d_dina = 0;
        bus3.i_x_req = 0; bus3.i_x_we = 0; bus3.i_x_addr = 0; bus3.i_x_dina = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstStatus", {bus.q_busy, bus.q_grant, bus.q_err}, 0);
        checkOutput("rstMem", {bus.q_mem_ce, bus.q_mem_we, bus.q_mem_addr, bus.q_mem_dina}, 0);
        checkOutput("rstAcks", {bus.q_f_ack, bus.q_d_ack, bus.q_x_ack}, 0);
        checkOutput("rstData", {bus.q_f_data, bus.q_d_data} | {16'h0, bus.q_x_data}, 0);
        rst_n = 1'b1;

        // F-only read of 0x0005
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PF, 1'b0, 16'h0005, 16'h0);
        pushMem(16'h0005, 1'b0, 16'h0, c0 + 1);
        pushAck(PF, 16'h2002, 1'b0, c0 + 3);
        @(negedge clk);
        checkOutput("t1GrantIssue", bus.q_grant, PF);
        @(negedge clk);
        checkOutput("t1GrantWait", bus.q_grant, PF);
        checkOutput("t1BusyWait", bus.q_busy, 1);
        runUntilIdle(20);

        // D store and F fetch together: D first, then F
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PD, 1'b1, 16'h00AA, 16'h00CA);
        applyStimulus(PF, 1'b0, 16'h0005, 16'h0);
        pushMem(16'h00AA, 1'b1, 16'h00CA, c0 + 1);
        pushAck(PD, 16'h0000, 1'b0, c0 + 3);
        pushMem(16'h0005, 1'b0, 16'h0, c0 + 5);
        pushAck(PF, 16'h2002, 1'b0, c0 + 7);
        runUntilIdle(30);

        // D load of the stored word
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PD, 1'b0, 16'h00AA, 16'h0);
        pushMem(16'h00AA, 1'b0, 16'h0, c0 + 1);
        pushAck(PD, 16'h00CA, 1'b0, c0 + 3);
        runUntilIdle(20);

        // Out-of-range D read: no strobe, err with ack, data zero
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PD, 1'b0, 16'h0100, 16'h0);
        pushAck(PD, 16'h0000, 1'b1, c0 + 3);
        runUntilIdle(20);

        // Starvation: D/F held, X held; X wins the 5th arbitration, then
        // must lose four more before winning again
        starveOrder = '{PD, PF, PD, PF, PX, PD, PF, PD, PF, PD, PX};
        for (int i = 0; i < 11; i++) begin
            case (starveOrder[i])
                PD: begin pushMem(16'h0010, 1'b0, 16'h0, -1); pushAck(PD, 16'hA010, 1'b0, -1); end
                PF: begin pushMem(16'h0020, 1'b0, 16'h0, -1); pushAck(PF, 16'hA020, 1'b0, -1); end
                default: begin pushMem(16'h0030, 1'b0, 16'h0, -1); pushAck(PX, 16'hA030, 1'b0, -1); end
            endcase
        end
        @(negedge clk);
        applyStimulus(PD, 1'b0, 16'h0010, 16'h0);
        applyStimulus(PF, 1'b0, 16'h0020, 16'h0);
        applyStimulus(PX, 1'b0, 16'h0030, 16'h0);
        xAcks = 0;
        xRaiseAt = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.q_x_ack) begin
                xAcks++;
                bus.i_x_req = 1'b0;
                if (xAcks == 1) begin
                    xRaiseAt = cyc + 2;
                end else begin
                    bus.i_d_req = 1'b0;
                    bus.i_f_req = 1'b0;
                end
            end
            if (cyc == xRaiseAt) bus.i_x_req = 1'b1;
            if (xAcks == 2 && !bus.q_busy) break;
        end
        checkOutput("starveXAcks", xAcks, 2);
        bus.i_d_req = 1'b0; bus.i_f_req = 1'b0; bus.i_x_req = 1'b0;
        runUntilIdle(20);

        // Reset during WAIT of an X write: outputs clear, no ack follows
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PX, 1'b1, 16'h0040, 16'h1234);
        pushMem(16'h0040, 1'b1, 16'h1234, c0 + 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5BusyInWait", bus.q_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5RstStatus", {bus.q_busy, bus.q_grant, bus.q_err, bus.q_x_ack}, 0);
        checkOutput("t5RstData", {bus.q_f_data, bus.q_x_data}, 0);
        checkOutput("t5RstMem", {bus.q_mem_ce, bus.q_mem_addr}, 0);
        bus.i_x_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        c0 = cyc;
        applyStimulus(PF, 1'b0, 16'h0000, 16'h0);
        pushMem(16'h0000, 1'b0, 16'h0, c0 + 1);
        pushAck(PF, 16'hA000, 1'b0, c0 + 3);
        runUntilIdle(20);
        repeat (3) @(negedge clk);

        // Three-cycle memory latency: ack five cycles after the request
        @(negedge clk);
        c0 = cyc;
        bus3.i_f_addr = 16'h0005;
        bus3.i_f_req = 1'b1;
        got3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus3.q_mem_ce) begin
                checkOutput("lat3CeCycle", cyc, c0 + 1);
                checkOutput("lat3CeAddr", bus3.q_mem_addr, 16'h0005);
            end
            if (bus3.q_f_ack) begin
                checkOutput("lat3AckCycle", cyc, c0 + 5);
                checkOutput("lat3Data", bus3.q_f_data, 16'h2002);
                bus3.i_f_req = 1'b0;
                got3 = 1'b1;
                break;
            end
        end
        checkOutput("lat3AckSeen", got3, 1);
        bus3.i_f_req = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("ackQueueEmpty", expAck.size(), 0);
        checkOutput("memQueueEmpty", expMem.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
